// File: rtl/vga_ledbar_renderer.sv
// vga_ledbar_renderer
//   Draws N_CH full-height vertical bars across the active display, one per
//   bit of `led` (MSB leftmost). The led word is snapshotted at pixel (0,0)
//   so a frame never tears. Output is registered: one cycle of latency.
//   Bar position is tracked with an index/offset counter pair rather than a
//   divider; any valid pixel at x==0 resynchronises the counters.
//   Optional feature macro: LEDBAR_HIGHLIGHT_EN. When defined, each bar whose
//   bit changed at a frame start is drawn in HL_COLOR for HL_FRAMES frames.
module vga_ledbar_renderer #(
    parameter int          N_CH      = 16,
    parameter int          H_DISP    = 640,
    parameter int          V_DISP    = 480,
    parameter logic [11:0] ON_COLOR  = 12'hFFF,
    parameter logic [11:0] OFF_COLOR = 12'h000,
    parameter int          GAP_W     = 0,
    parameter logic [11:0] GAP_COLOR = 12'h444,
    parameter logic [11:0] HL_COLOR  = 12'h0F0,
    parameter int          HL_FRAMES = 30
) (
    input  logic            vga_clk,
    input  logic            vga_rst_n,
    input  logic [10:0]     pixel_xpos,
    input  logic [10:0]     pixel_ypos,
    input  logic            pixel_valid,
    input  logic [N_CH-1:0] led,
    output logic [11:0]     pixel_data,
    output logic            frame_start
);

    localparam int BAR_W = H_DISP / N_CH;
    localparam int IDX_W = $clog2(N_CH);
    localparam int OFF_W = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_CH - 1);
    localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(BAR_W - 1);

    // Elaboration-time parameter sanity checks
    generate
        if (N_CH < 2 || N_CH > 32) begin : g_bad_nch
            $error("vga_ledbar_renderer: N_CH must be in 2..32");
        end
        if (H_DISP < N_CH || H_DISP > 2048 || V_DISP < 1 || V_DISP > 2048) begin : g_bad_disp
            $error("vga_ledbar_renderer: display size out of range");
        end
        if (GAP_W < 0 || GAP_W >= BAR_W) begin : g_bad_gap
            $error("vga_ledbar_renderer: GAP_W must be smaller than the bar width");
        end
    endgenerate

    logic [IDX_W-1:0] idx_r, cur_idx;
    logic [OFF_W-1:0] off_r, cur_off;
    logic [N_CH-1:0]  led_shadow, cur_shadow;
    logic             is_line_start, is_frame_start;
    logic             bar_bit, in_gap, cur_hl;
    logic [11:0]      pix_next;

    // Position of the pixel being presented this cycle, derived from the
    // position of the previous valid pixel (or reset to bar 0 at x==0).
    always_comb begin
        is_line_start  = pixel_valid && (pixel_xpos == 11'd0);
        is_frame_start = is_line_start && (pixel_ypos == 11'd0);
        cur_idx        = idx_r;
        cur_off        = off_r;
        if (is_line_start) begin
            cur_idx = '0;
            cur_off = '0;
        end else if (off_r == OFF_LAST) begin
            cur_off = '0;
            // The last bar soaks up the H_DISP % N_CH remainder pixels
            if (idx_r != IDX_LAST) cur_idx = idx_r + 1'b1;
        end else begin
            cur_off = off_r + 1'b1;
        end
    end

    // Pixel (0,0) already renders with the freshly captured led word
    assign cur_shadow = is_frame_start ? led : led_shadow;
    assign bar_bit    = cur_shadow[IDX_LAST - cur_idx];
    assign in_gap     = (GAP_W > 0) && (cur_idx != IDX_LAST) &&
                        (int'(cur_off) >= BAR_W - GAP_W);

`ifdef LEDBAR_HIGHLIGHT_EN
    localparam int HL_W = $clog2(HL_FRAMES + 1);
    localparam logic [HL_W-1:0] HL_LOAD = HL_W'(HL_FRAMES);

    generate
        if (HL_FRAMES < 1) begin : g_bad_hl
            $error("vga_ledbar_renderer: HL_FRAMES must be at least 1");
        end
    endgenerate

    logic [N_CH-1:0][HL_W-1:0] hl_cnt, hl_next;
    logic [N_CH-1:0]           hl_active;

    // Per-channel countdown: reload on a captured change, else tick down once
    // per frame. The updated value is what pixel (0,0) sees.
    for (genvar i = 0; i < N_CH; i++) begin : g_hl
        assign hl_next[i] = !is_frame_start           ? hl_cnt[i] :
                            (led[i] != led_shadow[i]) ? HL_LOAD :
                            (hl_cnt[i] != '0)         ? hl_cnt[i] - 1'b1 :
                                                        hl_cnt[i];
        assign hl_active[i] = (hl_next[i] != '0);
    end

    // Highlight counter state
    always_ff @(posedge vga_clk or negedge vga_rst_n) begin
        if (!vga_rst_n) hl_cnt <= '0;
        else            hl_cnt <= hl_next;
    end

    assign cur_hl = hl_active[IDX_LAST - cur_idx];
`else
    logic unused_hl_frames;
    assign unused_hl_frames = ^HL_FRAMES;
    assign cur_hl           = 1'b0;
`endif

    // Colour priority: blanking, separator, highlight, on/off
    always_comb begin
        pix_next = 12'h000;
        if (pixel_valid) begin
            if (in_gap)       pix_next = GAP_COLOR;
            else if (cur_hl)  pix_next = HL_COLOR;
            else if (bar_bit) pix_next = ON_COLOR;
            else              pix_next = OFF_COLOR;
        end
    end

    // Output register, bar counters and frame snapshot; counters hold in blanking
    always_ff @(posedge vga_clk or negedge vga_rst_n) begin
        if (!vga_rst_n) begin
            idx_r       <= '0;
            off_r       <= '0;
            led_shadow  <= '0;
            pixel_data  <= 12'h000;
            frame_start <= 1'b0;
        end else begin
            pixel_data  <= pix_next;
            frame_start <= is_frame_start;
            if (pixel_valid) begin
                idx_r <= cur_idx;
                off_r <= cur_off;
            end
            if (is_frame_start) led_shadow <= led;
        end
    end

endmodule

// File: tb/tb_vga_ledbar_renderer.sv
// Bench for vga_ledbar_renderer: two instances (16 bars no gap, 12 bars with
// 2-pixel gap) driven from the same timing stream, compared every cycle to a
// position/division based reference model, plus constant-table checks.
module tb_vga_ledbar_renderer;

    localparam int HLF = 2;
`ifdef LEDBAR_HIGHLIGHT_EN
    localparam bit HL_ON = 1'b1;
`else
    localparam bit HL_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] x = '0, y = '0;
    logic        vld = 1'b0;
    logic [15:0] led16 = '0;
    logic [11:0] led12 = '0;
    logic [11:0] pd16, pd12;
    logic        fs16, fs12;

    always #5 clk = ~clk;

    vga_ledbar_renderer #(.N_CH(16), .GAP_W(0), .HL_FRAMES(HLF)) u16 (
        .vga_clk(clk), .vga_rst_n(rst_n), .pixel_xpos(x), .pixel_ypos(y),
        .pixel_valid(vld), .led(led16), .pixel_data(pd16), .frame_start(fs16));

    vga_ledbar_renderer #(.N_CH(12), .GAP_W(2), .HL_FRAMES(HLF)) u12 (
        .vga_clk(clk), .vga_rst_n(rst_n), .pixel_xpos(x), .pixel_ypos(y),
        .pixel_valid(vld), .led(led12), .pixel_data(pd12), .frame_start(fs12));

    int checks = 0, failures = 0;

    // reference model state: pixels since line start, shadows, frames left
    int          pos;
    logic [15:0] sh16;
    logic [11:0] sh12;
    int          hl16[16];
    int          hl12[12];

    logic [11:0] cap16[640];
    logic [11:0] cap12[640];
    bit          cap_en = 1'b0;
    int          fs_seen;

    typedef struct {
        int          px;
        logic [11:0] e16;
        logic [11:0] e12;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string name, input logic [11:0] got, input logic [11:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [11:0] colour(input int n, input int gapw, input int p,
                                           input logic [31:0] sh, input logic [31:0] hlm);
        int bw, bar, off;
        bw  = 640 / n;
        bar = p / bw;
        off = p % bw;
        if (bar > n - 1) bar = n - 1;
        if (gapw > 0 && bar < n - 1 && off >= bw - gapw) return 12'h444;
        if (hlm[n-1-bar]) return 12'h0F0;
        return sh[n-1-bar] ? 12'hFFF : 12'h000;
    endfunction

    task automatic model_reset();
        pos  = 0;
        sh16 = '0;
        sh12 = '0;
        for (int i = 0; i < 16; i++) hl16[i] = 0;
        for (int i = 0; i < 12; i++) hl12[i] = 0;
    endtask

    // Apply one pixel, advance the model, check outputs one cycle later
    task automatic step(input logic [10:0] px, input logic [10:0] py, input logic pv);
        logic [11:0] e16, e12;
        logic        efs;
        logic [31:0] m16, m12;
        x = px; y = py; vld = pv;
        e16 = '0; e12 = '0; efs = 1'b0;
        if (pv) begin
            if (px == 0) pos = 0;
            else pos++;
            if (px == 0 && py == 0) begin
                efs = 1'b1;
                if (HL_ON) begin
                    for (int i = 0; i < 16; i++)
                        hl16[i] = (led16[i] != sh16[i]) ? HLF : (hl16[i] > 0 ? hl16[i] - 1 : 0);
                    for (int i = 0; i < 12; i++)
                        hl12[i] = (led12[i] != sh12[i]) ? HLF : (hl12[i] > 0 ? hl12[i] - 1 : 0);
                end
                sh16 = led16;
                sh12 = led12;
            end
            m16 = '0; m12 = '0;
            for (int i = 0; i < 16; i++) m16[i] = (hl16[i] > 0);
            for (int i = 0; i < 12; i++) m12[i] = (hl12[i] > 0);
            e16 = colour(16, 0, pos, {16'd0, sh16}, m16);
            e12 = colour(12, 2, pos, {20'd0, sh12}, m12);
        end
        @(posedge clk); #1;
        chk("pix16", pd16, e16);
        chk("pix12", pd12, e12);
        chk("fs16", {11'd0, fs16}, {11'd0, efs});
        chk("fs12", {11'd0, fs12}, {11'd0, efs});
        if (cap_en) begin
            if (pv) begin
                cap16[px] = pd16;
                cap12[px] = pd12;
            end
            if (fs16) fs_seen++;
        end
    endtask

    task automatic line(input logic [10:0] ly, input int porch);
        for (int i = 0; i < 640; i++) step(11'(i), ly, 1'b1);
        for (int i = 0; i < porch; i++)
            step(11'($urandom_range(0, 2047)), 11'($urandom_range(0, 2047)), 1'b0);
    endtask

    task automatic cap_line(input logic [10:0] ly);
        cap_en  = 1'b1;
        fs_seen = 0;
        line(ly, 10);
        cap_en  = 1'b0;
    endtask

    initial begin
        // led16=8001, led12=FFF expectations by column
        tbl[0]  = '{0,   12'hFFF, 12'hFFF};
        tbl[1]  = '{39,  12'hFFF, 12'hFFF};
        tbl[2]  = '{40,  12'h000, 12'hFFF};
        tbl[3]  = '{51,  12'h000, 12'h444};
        tbl[4]  = '{52,  12'h000, 12'h444};
        tbl[5]  = '{53,  12'h000, 12'hFFF};
        tbl[6]  = '{582, 12'h000, 12'h444};
        tbl[7]  = '{583, 12'h000, 12'hFFF};
        tbl[8]  = '{599, 12'h000, 12'hFFF};
        tbl[9]  = '{600, 12'hFFF, 12'hFFF};
        tbl[10] = '{635, 12'hFFF, 12'hFFF};
        tbl[11] = '{639, 12'hFFF, 12'hFFF};

        model_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_pix16", pd16, 12'h000);
        chk("rst_pix12", pd12, 12'h000);
        chk("rst_fs16", {11'd0, fs16}, 12'd0);
        rst_n = 1'b1;

        // static pattern; third frame is past any highlight window
        led16 = 16'h8001;
        led12 = 12'hFFF;
        line(0, 10);
        line(0, 10);
        cap_line(0);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("tbl16_x%0d", tbl[i].px), cap16[tbl[i].px], tbl[i].e16);
            chk($sformatf("tbl12_x%0d", tbl[i].px), cap12[tbl[i].px], tbl[i].e12);
        end
        chk("fs_once", 12'(fs_seen), 12'd1);

        // mid-frame led change is invisible until the next frame
        led16 = 16'hFFFF;
        line(0, 10);
        line(0, 10);
        line(0, 10);
        led16 = 16'h0000;
        line(1, 10);
        cap_line(2);
        chk("tear_x0", cap16[0], 12'hFFF);
        chk("tear_x320", cap16[320], 12'hFFF);
        cap_line(0);
        chk("next_x320", cap16[320], HL_ON ? 12'h0F0 : 12'h000);

        // single-bit toggle: only bar 0 highlighted, for exactly HLF frames
        line(0, 10);
        line(0, 10);
        led16 = 16'h8000;
        cap_line(0);
        chk("hl_f1_x0", cap16[0], HL_ON ? 12'h0F0 : 12'hFFF);
        chk("hl_f1_x40", cap16[40], 12'h000);
        cap_line(0);
        chk("hl_f2_x0", cap16[0], HL_ON ? 12'h0F0 : 12'hFFF);
        cap_line(0);
        chk("hl_f3_x0", cap16[0], 12'hFFF);

        // porch then resync on a new line after a truncated one
        for (int i = 0; i < 300; i++) step(11'(i), 11'd1, 1'b1);
        for (int i = 0; i < 15; i++) step(11'd0, 11'd0, 1'b0);
        cap_line(2);
        chk("resync_x0", cap16[0], 12'hFFF);
        chk("resync_x40", cap16[40], 12'h000);

        // reset mid-line with valid pixels
        led16 = 16'hFFFF;
        line(0, 10);
        for (int i = 0; i < 100; i++) step(11'(i), 11'd1, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_pix16", pd16, 12'h000);
        chk("rstmid_pix12", pd12, 12'h000);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("rsthold_pix16", pd16, 12'h000);
            chk("rsthold_fs16", {11'd0, fs16}, 12'd0);
        end
        model_reset();
        rst_n = 1'b1;
        for (int i = 100; i < 640; i++) step(11'(i), 11'd1, 1'b1);
        line(0, 10);

        // randomized frames: blanking bubbles, x jumps, led changes anytime
        for (int f = 0; f < 6; f++) begin
            for (int ly = 0; ly < 3; ly++) begin
                for (int i = 0; i < 640; i++) begin
                    if ($urandom_range(0, 499) == 0) begin
                        led16 = 16'($urandom);
                        led12 = 12'($urandom);
                    end
                    if ($urandom_range(0, 7) == 0)
                        repeat ($urandom_range(1, 3))
                            step(11'($urandom_range(0, 2047)), 11'($urandom_range(0, 2047)), 1'b0);
                    if ($urandom_range(0, 199) == 0)
                        step(11'($urandom_range(1, 639)), 11'(ly), 1'b1);
                    else
                        step(11'(i), 11'(ly), 1'b1);
                end
                for (int i = 0; i < int'($urandom_range(5, 20)); i++)
                    step(11'($urandom_range(0, 2047)), 11'($urandom_range(0, 2047)), 1'b0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
